// File: rtl/seq_mult_if.sv
// Request/response bundle for the two-requester shared Booth multiplier.
interface seq_mult_if #(parameter int WIDTH = 32);
  logic signed [WIDTH-1:0]   A0, B0, A1, B1;
  logic                      valid0, ready0, valid1, ready1;
  logic signed [2*WIDTH-1:0] P;
  logic                      resp_valid0, resp_valid1;
  logic                      resp_ready0, resp_ready1;
  logic                      busy;

  modport master (
    output A0, B0, valid0, A1, B1, valid1, resp_ready0, resp_ready1,
    input  ready0, ready1, P, resp_valid0, resp_valid1, busy
  );

  modport slave (
    input  A0, B0, valid0, A1, B1, valid1, resp_ready0, resp_ready1,
    output ready0, ready1, P, resp_valid0, resp_valid1, busy
  );
endinterface

// File: rtl/seq_mult_scheduler.sv
// Round-robin arbiter in front of one radix-2 Booth shift-add multiplier;
// one operation in flight, result held until the owning requester consumes it.
module seq_mult_scheduler #(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     rst,
  seq_mult_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam int CW = $clog2(WIDTH + 1);

  logic [1:0]              state;
  logic                    last_grant, owner;
  logic [CW-1:0]           cnt;
  logic [WIDTH-1:0]        mcand;
  logic [WIDTH:0]          acc;   // one guard bit so -mcand fits for the most negative operand
  logic [WIDTH-1:0]        mplr;
  logic                    q_1;
  logic signed [2*WIDTH-1:0] p_q;
  logic                    rv0, rv1;
  logic                    rdy0, rdy1;

  logic [WIDTH:0] m_ext, sum;

  // both valid -> the one that did not win last time
  always_comb begin
    rdy0 = (state == IDLE) && bus.valid0 && (!bus.valid1 ||  last_grant);
    rdy1 = (state == IDLE) && bus.valid1 && (!bus.valid0 || !last_grant);
  end

  always_comb begin
    m_ext = {mcand[WIDTH-1], mcand};
    unique case ({mplr[0], q_1})
      2'b01:   sum = acc + m_ext;
      2'b10:   sum = acc - m_ext;
      default: sum = acc;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      cnt        <= '0;
      mcand      <= '0;
      acc        <= '0;
      mplr       <= '0;
      q_1        <= 1'b0;
      p_q        <= '0;
      rv0        <= 1'b0;
      rv1        <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (rdy0 || rdy1) begin
            mcand      <= rdy0 ? bus.A0 : bus.A1;
            mplr       <= rdy0 ? bus.B0 : bus.B1;
            owner      <= rdy1;
            last_grant <= rdy1;
            acc        <= '0;
            q_1        <= 1'b0;
            cnt        <= '0;
            state      <= RUN;
          end
        end
        RUN: begin
          // add/sub then arithmetic shift of {acc, mplr, q_1}
          acc  <= {sum[WIDTH], sum[WIDTH:1]};
          mplr <= {sum[0], mplr[WIDTH-1:1]};
          q_1  <= mplr[0];
          cnt  <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) state <= DONE;
        end
        DONE: begin
          // first DONE cycle publishes the result; afterwards wait for the owner
          if (!rv0 && !rv1) begin
            p_q <= {acc[WIDTH-1:0], mplr};
            rv0 <= !owner;
            rv1 <= owner;
          end else if (owner ? bus.resp_ready1 : bus.resp_ready0) begin
            rv0   <= 1'b0;
            rv1   <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ready0      = rdy0;
  assign bus.ready1      = rdy1;
  assign bus.P           = p_q;
  assign bus.resp_valid0 = rv0;
  assign bus.resp_valid1 = rv1;
  assign bus.busy        = (state != IDLE);

endmodule

// File: tb/tb_seq_mult_scheduler.sv
// Scoreboard bench for seq_mult_scheduler: expected products queued at acceptance, checked on response.
module tb_seq_mult_scheduler;

  localparam int W = 32;

  typedef struct {
    bit                 id;
    logic signed [63:0] p;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   acc_cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  exp_t sb[$];

  seq_mult_if #(.WIDTH(W)) bus ();

  seq_mult_scheduler #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic signed [63:0] prod(input logic signed [31:0] a, input logic signed [31:0] b);
    logic signed [63:0] ax, bx;
    ax = a;
    bx = b;
    return ax * bx;
  endfunction

  task automatic push(input bit id, input logic signed [31:0] a, input logic signed [31:0] b);
    exp_t e;
    e.id = id;
    e.p  = prod(a, b);
    sb.push_back(e);
  endtask

  // drive one request, wait (bounded) for grant, record acceptance
  task automatic issue(input bit id, input logic signed [31:0] a, input logic signed [31:0] b);
    int  n = 0;
    logic g;
    @(negedge clk);
    if (id) begin bus.A1 = a; bus.B1 = b; bus.valid1 = 1'b1; end
    else    begin bus.A0 = a; bus.B0 = b; bus.valid0 = 1'b1; end
    #1;
    g = id ? bus.ready1 : bus.ready0;
    while (!g && n < 50) begin
      @(negedge clk); #1;
      g = id ? bus.ready1 : bus.ready0;
      n++;
    end
    chk("grant", g, 1'b1);
    @(posedge clk); #1;
    acc_cyc = cyc;
    if (g) push(id, a, b);
    if (id) bus.valid1 = 1'b0; else bus.valid0 = 1'b0;
  endtask

  // wait for a response, compare against the scoreboard, optionally stall, then consume
  task automatic collect(input int hold);
    exp_t e;
    int   n = 0;
    logic seen = 1'b0;
    logic rdy_leak = 1'b0;
    while (!seen && n < 60) begin
      @(negedge clk);
      seen = bus.resp_valid0 | bus.resp_valid1;
      if (!seen) rdy_leak = rdy_leak | ((bus.ready0 | bus.ready1) & bus.busy);
      n++;
    end
    chk("resp_seen", seen, 1'b1);
    chk("ready_low_busy", rdy_leak, 1'b0);
    if (!seen || sb.size() == 0) return;
    e = sb.pop_front();
    chk("latency", 64'(cyc - acc_cyc), 64'(W + 1));
    chk("rv0", bus.resp_valid0, !e.id);
    chk("rv1", bus.resp_valid1, e.id);
    chk("P", bus.P, e.p);
    for (int i = 0; i < hold; i++) begin
      if (e.id) bus.resp_ready0 = 1'b1; else bus.resp_ready1 = 1'b1;
      @(negedge clk);
      if (e.id) bus.resp_ready0 = 1'b0; else bus.resp_ready1 = 1'b0;
      chk("hold_P", bus.P, e.p);
      chk("hold_rv", {bus.resp_valid1, bus.resp_valid0}, e.id ? 2'b10 : 2'b01);
      chk("hold_ready", bus.ready0 | bus.ready1, 1'b0);
    end
    if (e.id) bus.resp_ready1 = 1'b1; else bus.resp_ready0 = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready0 = 1'b0;
    bus.resp_ready1 = 1'b0;
    chk("idle_busy", bus.busy, 1'b0);
    chk("idle_rv", {bus.resp_valid1, bus.resp_valid0}, 2'b00);
    chk("idle_P", bus.P, e.p);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: timeout reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    logic signed [31:0] ra, rb;
    bit rid;
    bus.A0 = '0; bus.B0 = '0; bus.A1 = '0; bus.B1 = '0;
    bus.valid0 = 1'b0; bus.valid1 = 1'b0;
    bus.resp_ready0 = 1'b0; bus.resp_ready1 = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_P", bus.P, 64'd0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_rv", {bus.resp_valid1, bus.resp_valid0}, 2'b00);
    chk("rst_ready", {bus.ready1, bus.ready0}, 2'b00);
    @(negedge clk); rst = 1'b0;

    // contention after reset: requester 0 first, then 1, then 0 again
    for (int r = 0; r < 2; r++) begin
      @(negedge clk);
      bus.A0 = -10;  bus.B0 = -150; bus.valid0 = 1'b1;
      bus.A1 = -150; bus.B1 = 150;  bus.valid1 = 1'b1;
      #1;
      chk("cont_ready", {bus.ready1, bus.ready0}, 2'b01);
      @(posedge clk); #1;
      acc_cyc = cyc; push(1'b0, -10, -150); bus.valid0 = 1'b0;
      chk("cont_busy", bus.busy, 1'b1);
      collect(0);
      @(negedge clk); #1;
      chk("cont_ready_next", {bus.ready1, bus.ready0}, 2'b10);
      @(posedge clk); #1;
      acc_cyc = cyc; push(1'b1, -150, 150); bus.valid1 = 1'b0;
      collect(0);
    end

    // single request, then backpressure with non-owner resp_ready pulses
    issue(1'b0, 10, -150);
    collect(0);
    issue(1'b0, 1234, -567);
    collect(10);
    issue(1'b1, -77, 91);
    collect(4);

    // corner operands
    issue(1'b0, 0, 150);             collect(0);
    issue(1'b1, 1, 150);             collect(0);
    issue(1'b0, 32'sh8000_0000, 32'sh8000_0000); collect(0);
    issue(1'b1, 32'sh8000_0000, 1);  collect(0);
    issue(1'b0, 32'sh7fff_ffff, 32'sh8000_0000); collect(0);

    // operands changing after acceptance must not matter
    issue(1'b0, 321, -45);
    bus.A0 = 999; bus.B0 = -999;
    collect(0);

    for (int i = 0; i < 4; i++) begin
      ra = $urandom; rb = $urandom; rid = 1'($urandom_range(0, 1));
      issue(rid, ra, rb);
      collect(i);
    end

    // reset mid-run aborts silently
    issue(1'b0, 2, 4);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_P", bus.P, 64'd0);
    chk("mid_rst_busy", bus.busy, 1'b0);
    chk("mid_rst_rv", {bus.resp_valid1, bus.resp_valid0}, 2'b00);
    sb.delete();
    @(negedge clk); rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      seen = seen | bus.resp_valid0 | bus.resp_valid1 | bus.busy;
    end
    chk("mid_rst_no_resp", seen, 1'b0);
    issue(1'b1, 10, 22);
    collect(0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_mult_scheduler.md
SEQ_MULT_SCHEDULER -- requirements
Module: seq_mult_scheduler

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand width in bits; the product width is 2*WIDTH.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have ports A0, B0, input, WIDTH each: signed two's-complement operands of requester 0.
REQ-005 SHALL have port valid0, input, 1 bit: requester 0 presents an operand pair.
REQ-006 SHALL have port ready0, output, 1 bit: requester 0's operands are accepted this cycle.
REQ-007 SHALL have ports A1, B1, valid1 (inputs) and ready1 (output), with the same widths and meanings for requester 1.
REQ-008 SHALL have port P, output, 2*WIDTH: signed product shared by both requesters.
REQ-009 SHALL have ports resp_valid0 and resp_valid1, output, 1 bit each: P holds the result for that requester.
REQ-010 SHALL have ports resp_ready0 and resp_ready1, input, 1 bit each: that requester consumes P.
REQ-011 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-012 SHALL implement states IDLE, RUN and DONE with one shared radix-2 Booth shift-add datapath.
REQ-013 In IDLE, SHALL assert at most one ready; the grant is combinational from valid0/valid1 and the last_grant register.
REQ-014 SHALL grant the only valid requester when exactly one requester is valid.
REQ-015 SHALL grant the requester other than last_grant when both are valid (round-robin).
REQ-016 SHALL accept a request on an edge where validX and readyX are both high, then:
- latch AX and BX;
- record owner = X;
- update last_grant = X;
- clear the step counter;
- enter RUN.
REQ-017 In RUN, SHALL perform exactly one Booth step per cycle for WIDTH cycles (counter 0..WIDTH-1), then enter DONE.
REQ-018 SHALL assert resp_valid of the owner only, exactly WIDTH+1 cycles after the acceptance edge (33 for WIDTH=32).
REQ-019 SHALL make P equal to the exact signed product A*B, including -2^(WIDTH-1) * -2^(WIDTH-1) = 2^(2*WIDTH-2).
REQ-020 SHALL ignore operand-input changes after acceptance.
REQ-021 In DONE, SHALL hold P and resp_valid stable until resp_ready of the owner is high.
REQ-022 On the edge where the owner's resp_ready is high, SHALL return to IDLE with resp_valid deasserted.
REQ-023 SHALL ignore resp_ready of the non-owner.
REQ-024 SHALL hold ready0 and ready1 low in RUN and DONE; no request is accepted in the cycle DONE exits, so there is a one-cycle IDLE bubble.
REQ-025 SHALL hold P at its last result value while in IDLE and RUN.
REQ-026 SHALL hold the requester's ready low when its valid is low, regardless of last_grant.

Reset
REQ-027 Assertion of rst SHALL immediately clear all state, asynchronously:
- state = IDLE;
- last_grant = 1, so requester 0 wins the first contention;
- counter = 0;
- P = 0;
- resp_valid0, resp_valid1 and busy = 0.
REQ-028 rst asserted during RUN or DONE SHALL abort the operation and produce no response; after release the scheduler accepts new requests normally.

Verification
REQ-029 Single request: valid0 with A0=10, B0=-150 -> ready0 high one cycle, busy high, resp_valid0 high 33 cycles later with P=-1500; resp_valid1 stays low.
REQ-030 Contention after reset: valid0 and valid1 high together, (A0,B0)=(-10,-150), (A1,B1)=(-150,150):
- requester 0 is served first with P=1500;
- requester 1 is served next with P=-22500;
- a following simultaneous request is served to requester 0 first.
REQ-031 Backpressure: resp_ready0 held low for 10 cycles in DONE -> P and resp_valid0 stable; resp_ready1 pulses are ignored; one cycle after resp_ready0 rises, the state returns to IDLE.
REQ-032 Corner operands, checked against the expected products:
- A=0, B=150 -> P=0;
- A=1, B=150 -> P=150;
- A=-2^31, B=-2^31 -> P=2^62;
- A=-2^31, B=1 -> P=-2^31.
REQ-033 Reset mid-run: rst pulsed 5 cycles after acceptance of A0=2, B0=4 -> outputs zero immediately; no resp_valid ever appears for that request; a new request (A1=10, B1=22) completes with P=220.
REQ-034 Operand change after acceptance: A0 and B0 changed while busy -> the result still reflects the latched values.
